display_scanner: RTL and testbench

- Time-multiplexed driver for the board's common-anode seven-segment bank.
- Holds a hex value and scans one digit at a time, presenting that digit's nibble on digit_data to the downstream per-digit seven-segment decoder.
- Drives the active-low anodes and the active-low decimal point.
- New values are accepted via a load/ack handshake and applied only at a frame boundary, so no partially updated frame is ever shown.

---
 rtl/display_scanner_if.sv | 13 +
 rtl/display_scanner.sv | 125 ++++++++++++
 tb/tb_display_scanner.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// Load/ack handshake bundle for display_scanner: new hex value, decimal points,
// load strobe and the frame-aligned acknowledge.
interface display_scanner_if #(
  parameter int unsigned NDIGITS = 8
) ();
  logic [4*NDIGITS-1:0] value_in;
  logic [NDIGITS-1:0]   dp_in;
  logic                 load;
  logic                 load_ack;

  modport master (output value_in, output dp_in, output load, input load_ack);
  modport slave  (input value_in, input dp_in, input load, output load_ack);
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned loads.
// Optional leading-zero suppression when DISPLAY_LZ_BLANK_EN is defined.
module display_scanner #(
  parameter int unsigned NDIGITS  = 8,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic               clk,
  input  logic               reset_n,
  display_scanner_if.slave   ld,
  output logic [3:0]         digit_data,
  output logic [NDIGITS-1:0] digit_an,
  output logic               dp_n,
  output logic               blank
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [PW-1:0]        pre_q, pre_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NDIGITS-1:0] disp_val_q, disp_val_d;
  logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIGITS-1:0] stage_val_q, stage_val_d;
  logic [NDIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic                 pending_q, pending_d;
  logic                 ack_q, ack_d;
  logic                 tick, frame_end;

  assign tick      = (pre_q == PRE_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  always_comb begin
    pre_d       = tick ? '0 : pre_q + 1'b1;
    idx_d       = idx_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    stage_val_d = stage_val_q;
    stage_dp_d  = stage_dp_q;
    pending_d   = pending_q;
    ack_d       = 1'b0;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // A load coinciding with frame_end skips the stage and is shown directly.
    if (frame_end) begin
      pending_d = 1'b0;
      if (ld.load) begin
        disp_val_d = ld.value_in;
        disp_dp_d  = ld.dp_in;
        ack_d      = 1'b1;
      end else if (pending_q) begin
        disp_val_d = stage_val_q;
        disp_dp_d  = stage_dp_q;
        ack_d      = 1'b1;
      end
    end else if (ld.load) begin
      stage_val_d = ld.value_in;
      stage_dp_d  = ld.dp_in;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q       <= '0;
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      stage_val_q <= '0;
      stage_dp_q  <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      stage_val_q <= stage_val_d;
      stage_dp_q  <= stage_dp_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
    end
  end

  assign ld.load_ack = ack_q;

`ifdef DISPLAY_LZ_BLANK_EN
  // zero_from[k]: every nibble from digit k up to the top digit is zero
  logic [NDIGITS-1:0] zero_from;
  always_comb begin
    logic acc;
    int unsigned k;
    acc       = 1'b1;
    zero_from = '0;
    for (int unsigned j = 0; j < NDIGITS; j++) begin
      k            = NDIGITS - 1 - j;
      acc          = acc & (disp_val_q[4*k +: 4] == 4'h0);
      zero_from[k] = acc;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int unsigned k = 1; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) blank = zero_from[k] & ~disp_dp_q[k];
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    digit_data = '0;
    digit_an   = '1;
    dp_n       = 1'b1;
    for (int unsigned k = 0; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        digit_data = disp_val_q[4*k +: 4];
        if (!blank) begin
          digit_an[k] = 1'b0;
          dp_n        = ~disp_dp_q[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (NDIGITS=4, PRESCALE=4).
module tb_display_scanner;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] digit_data;
  logic [3:0] digit_an;
  logic       dp_n;
  logic       blank;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  display_scanner_if #(.NDIGITS(4)) bus ();

  display_scanner #(.NDIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld         (bus),
    .digit_data (digit_data),
    .digit_an   (digit_an),
    .dp_n       (dp_n),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic adv_to(input int t);
    if (t > cyc) adv(t - cyc);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    adv(1);
    bus.load     = 1'b0;
  endtask

  logic [3:0] an_tbl [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int acks;
    int ones;
    int nonzero;
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dp_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(digit_an), 32'h0000_000E);
    chk("rst_data", 32'(digit_data), 32'h0);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_ack", 32'(bus.load_ack), 32'h0);
    reset_n = 1'b1;
    cyc     = 0;

    // scan stepping, 4 cycles per digit
    chk("scan_an", 32'(digit_an), 32'(an_tbl[0]));
    for (int c = 1; c < 20; c++) begin
      adv(1);
      chk("scan_an", 32'(digit_an), 32'(an_tbl[c/4]));
    end
    adv_to(20);

    // mid-frame load is held until frame_end at cycle 32
    do_load(16'hA3C5, 4'b0000);
    while (cyc < 32) begin
      chk("hold_data", 32'(digit_data), 32'h0);
      chk("hold_ack", 32'(bus.load_ack), 32'h0);
      adv(1);
    end
    chk("fe_ack", 32'(bus.load_ack), 32'h1);
    chk("fe_an", 32'(digit_an), 32'h0000_000E);
    chk("fe_d0", 32'(digit_data), 32'h5);
    adv(1);
    chk("ack_1cyc", 32'(bus.load_ack), 32'h0);
    adv_to(36); chk("d1", 32'(digit_data), 32'hC);
    adv_to(40); chk("d2", 32'(digit_data), 32'h3);
    adv_to(44); chk("d3", 32'(digit_data), 32'hA);

    // two loads in one frame: latest wins, single ack
    adv_to(50);
    do_load(16'h1111, 4'b0000);
    adv_to(54);
    do_load(16'h2222, 4'b0000);
    acks = 0;
    ones = 0;
    while (cyc < 79) begin
      if (bus.load_ack) acks++;
      if (digit_data == 4'h1) ones++;
      if (cyc == 64) begin
        chk("dbl_ack", 32'(bus.load_ack), 32'h1);
        chk("dbl_d0", 32'(digit_data), 32'h2);
      end
      if (cyc == 76) chk("dbl_d3", 32'(digit_data), 32'h2);
      adv(1);
    end
    chk("dbl_one_ack", 32'(acks), 32'h1);
    chk("dbl_never_1", 32'(ones), 32'h0);

    // load on the frame_end cycle itself (edge at 80)
    bus.value_in = 16'h00F0;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b1;
    adv(1);
    bus.load     = 1'b0;
    chk("byp_ack", 32'(bus.load_ack), 32'h1);
    chk("byp_d0", 32'(digit_data), 32'h0);
    adv(1);
    chk("byp_ack_1cyc", 32'(bus.load_ack), 32'h0);
    acks = 0;
    while (cyc <= 96) begin
      if (cyc == 84) chk("byp_d1", 32'(digit_data), 32'hF);
      if (bus.load_ack) acks++;
      adv(1);
    end
    chk("idle_fe_no_ack", 32'(acks), 32'h0);

    // leading-zero behaviour: 0x0042 visible from 112
    do_load(16'h0042, 4'b0000);
    adv_to(112);
    chk("lz_d0", 32'(digit_data), 32'h2);
    chk("lz_an0", 32'(digit_an), 32'h0000_000E);
    chk("lz_bl0", 32'(blank), 32'h0);
    adv_to(116);
    chk("lz_d1", 32'(digit_data), 32'h4);
    chk("lz_an1", 32'(digit_an), 32'h0000_000D);
    adv_to(120);
    chk("lz_d2", 32'(digit_data), 32'h0);
`ifdef DISPLAY_LZ_BLANK_EN
    chk("lz_bl2", 32'(blank), 32'h1);
    chk("lz_an2", 32'(digit_an), 32'h0000_000F);
`else
    chk("lz_bl2", 32'(blank), 32'h0);
    chk("lz_an2", 32'(digit_an), 32'h0000_000B);
`endif
    chk("lz_dp2", 32'(dp_n), 32'h1);
    adv_to(124);
`ifdef DISPLAY_LZ_BLANK_EN
    chk("lz_bl3", 32'(blank), 32'h1);
    chk("lz_an3", 32'(digit_an), 32'h0000_000F);
`else
    chk("lz_bl3", 32'(blank), 32'h0);
    chk("lz_an3", 32'(digit_an), 32'h0000_0007);
`endif

    // value 0: only digit 0 lit
    adv_to(125);
    do_load(16'h0000, 4'b0000);
    adv_to(128);
    chk("z_an0", 32'(digit_an), 32'h0000_000E);
    chk("z_bl0", 32'(blank), 32'h0);
    chk("z_d0", 32'(digit_data), 32'h0);
    adv_to(132);
`ifdef DISPLAY_LZ_BLANK_EN
    chk("z_an1", 32'(digit_an), 32'h0000_000F);
`else
    chk("z_an1", 32'(digit_an), 32'h0000_000D);
`endif

    // decimal point on digit 2 keeps that digit lit
    adv_to(133);
    do_load(16'h0000, 4'b0100);
    adv_to(148);
`ifdef DISPLAY_LZ_BLANK_EN
    chk("dp_an1", 32'(digit_an), 32'h0000_000F);
`else
    chk("dp_an1", 32'(digit_an), 32'h0000_000D);
`endif
    chk("dp_dpn1", 32'(dp_n), 32'h1);
    adv_to(152);
    chk("dp_an2", 32'(digit_an), 32'h0000_000B);
    chk("dp_bl2", 32'(blank), 32'h0);
    chk("dp_dpn2", 32'(dp_n), 32'h0);

    // reset with a pending load at idx 2
    adv_to(153);
    do_load(16'h1234, 4'b0000);
    reset_n = 1'b0;
    #1;
    chk("mrst_an", 32'(digit_an), 32'h0000_000E);
    chk("mrst_data", 32'(digit_data), 32'h0);
    chk("mrst_dp_n", 32'(dp_n), 32'h1);
    chk("mrst_ack", 32'(bus.load_ack), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    acks    = 0;
    nonzero = 0;
    while (cyc < 40) begin
      if (bus.load_ack) acks++;
      if (digit_data != 4'h0) nonzero++;
      adv(1);
    end
    chk("mrst_no_ack", 32'(acks), 32'h0);
    chk("mrst_val_zero", 32'(nonzero), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
